uart_rx_os: RTL and testbench

//  Oversampling UART receiver: 2FF sync, per-bit 3-sample majority vote, 5..8 data bits, opt. parity,
//  1/2 stop bits. Stores each character with its parity/frame flags in an RX FIFO. Adds false-start

---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_fifo_fwft_with_clear.sv | 81 ++++++++
 rtl/uart_rx_sampler.sv | 36 +++
 rtl/uart_rx_os.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

    localparam int unsigned RX_ENTRY_W  = 10;
    localparam int unsigned RX_FERR_BIT = 9;
    localparam int unsigned RX_PERR_BIT = 8;
    localparam int unsigned RX_DATA_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP0,
        ST_STOP1,
        ST_WAIT_IDLE
    } uart_rx_os_state_t;

    // 0..3 -> 5..8 data bits
    function automatic logic [3:0] data_bits_decode(input logic [1:0] sel);
        return 4'd5 + 4'(sel);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft_with_clear.sv
// First-word-fall-through FIFO with synchronous flush, level count and error pulses.
module sync_fifo_fwft_with_clear #(
    parameter  int unsigned DATA_WIDTH = 10,
    parameter  int unsigned DEPTH      = 16,
    localparam int unsigned PTR_W      = $clog2(DEPTH),
    localparam int unsigned LVL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [LVL_W-1:0]      level,
    output logic                  overflow,
    output logic                  underflow
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]      level_q, level_nxt;
    logic                  empty_q, full_q, ovf_q, unf_q;
    logic                  rd_ok_c, wr_ok_c;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write
    assign rd_ok_c = rd_en && !empty_q && !clear;
    assign wr_ok_c = wr_en && (!full_q || rd_ok_c) && !clear;

    always_comb begin
        level_nxt = level_q;
        if (clear) begin
            level_nxt = '0;
        end else if (wr_ok_c && !rd_ok_c) begin
            level_nxt = level_q + LVL_W'(1);
        end else if (rd_ok_c && !wr_ok_c) begin
            level_nxt = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (wr_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (rd_ok_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_nxt;
            empty_q <= (level_nxt == '0);
            full_q  <= (level_nxt == LVL_W'(DEPTH));
            ovf_q   <= !clear && wr_en && full_q && !rd_ok_c;
            unf_q   <= !clear && rd_en && empty_q;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data   = empty_q ? '0 : mem[rd_ptr_q];
    assign empty     = empty_q;
    assign full      = full_q;
    assign level     = level_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// Line conditioning: 2FF synchroniser, 3-sample majority vote and falling-edge detect.
module uart_rx_sampler (
    input  logic clk,
    input  logic rst,
    input  logic os_tick,
    input  logic rx_async,
    output logic vote_c,
    output logic fall_c
);

    (* ASYNC_REG = "TRUE" *) logic meta_q;
    (* ASYNC_REG = "TRUE" *) logic line_q;
    logic       prev_q;
    logic [1:0] hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            line_q <= 1'b1;
            prev_q <= 1'b1;
            hist_q <= 2'b11;
        end else begin
            meta_q <= rx_async;
            line_q <= meta_q;
            prev_q <= line_q;
            if (os_tick) begin
                hist_q <= {hist_q[0], line_q};
            end
        end
    end

    // The current synced value is the third sample, so the vote is valid on the tick itself
    assign vote_c = (hist_q[1] & hist_q[0]) | (hist_q[1] & line_q) | (hist_q[0] & line_q);
    assign fall_c = prev_q & ~line_q;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: frame FSM, RX FIFO, break/timeout/threshold status.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH    = 16,
    parameter  int unsigned OVERSAMPLE    = 16,
    parameter  int unsigned TIMEOUT_CHARS = 4,
    localparam int unsigned LVL_W         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_os_tick,
    input  logic                  i_rx_en,
    input  logic [1:0]            i_data_bits,
    input  logic                  i_use_parity,
    input  logic                  i_parity_odd,
    input  logic                  i_stop_bits,
    input  logic                  i_uart_rx,
    input  logic                  i_fifo_clear,
    input  logic                  i_fifo_rd_en,
    input  logic [LVL_W-1:0]      i_fifo_thresh,
    output logic [RX_ENTRY_W-1:0] o_fifo_rd_data,
    output logic                  o_fifo_empty,
    output logic                  o_fifo_full,
    output logic [LVL_W-1:0]      o_fifo_level,
    output logic                  o_thresh,
    output logic                  o_timeout,
    output logic                  o_break,
    output logic                  o_overflow_error,
    output logic                  o_underflow_error
);

    localparam int unsigned CNT_W      = $clog2(OVERSAMPLE);
    localparam int unsigned SAMPLE_CNT = OVERSAMPLE / 2 + 1;
    localparam int unsigned TO_TICKS   = TIMEOUT_CHARS * 10 * OVERSAMPLE;
    localparam int unsigned TO_W       = $clog2(TO_TICKS + 1);

    logic vote_c, fall_c;

    uart_rx_sampler u_sampler (
        .clk      (clk),
        .rst      (rst),
        .os_tick  (i_os_tick),
        .rx_async (i_uart_rx),
        .vote_c   (vote_c),
        .fall_c   (fall_c)
    );

    uart_rx_os_state_t     state_q, state_nxt;
    logic [CNT_W-1:0]      cnt_q, cnt_nxt;
    logic [2:0]            bit_q, bit_nxt;
    logic [RX_DATA_W-1:0]  data_q, data_nxt;
    logic                  par_q, par_nxt;
    logic                  ferr_q, ferr_nxt;
    logic                  perr_q, perr_nxt;
    logic [3:0]            nbits_q, nbits_nxt;
    logic                  use_par_q, use_par_nxt;
    logic                  odd_q, odd_nxt;
    logic                  stop2_q, stop2_nxt;
    logic                  wr_q, wr_nxt;
    logic                  brk_q, brk_nxt;
    logic [RX_ENTRY_W-1:0] entry_q, entry_nxt;
    logic                  sample_c, wrap_c;

    assign sample_c = i_os_tick && (cnt_q == CNT_W'(SAMPLE_CNT));
    assign wrap_c   = i_os_tick && (cnt_q == CNT_W'(OVERSAMPLE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            nbits_q   <= 4'd8;
            use_par_q <= 1'b0;
            odd_q     <= 1'b0;
            stop2_q   <= 1'b0;
            wr_q      <= 1'b0;
            brk_q     <= 1'b0;
            entry_q   <= '0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            bit_q     <= bit_nxt;
            data_q    <= data_nxt;
            par_q     <= par_nxt;
            ferr_q    <= ferr_nxt;
            perr_q    <= perr_nxt;
            nbits_q   <= nbits_nxt;
            use_par_q <= use_par_nxt;
            odd_q     <= odd_nxt;
            stop2_q   <= stop2_nxt;
            wr_q      <= wr_nxt;
            brk_q     <= brk_nxt;
            entry_q   <= entry_nxt;
        end
    end

    // Frame sequencing; config is latched at start so mid-frame changes do not disturb it
    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        bit_nxt     = bit_q;
        data_nxt    = data_q;
        par_nxt     = par_q;
        ferr_nxt    = ferr_q;
        perr_nxt    = perr_q;
        nbits_nxt   = nbits_q;
        use_par_nxt = use_par_q;
        odd_nxt     = odd_q;
        stop2_nxt   = stop2_q;
        wr_nxt      = 1'b0;
        brk_nxt     = 1'b0;
        entry_nxt   = '0;

        if (i_os_tick) begin
            cnt_nxt = wrap_c ? '0 : cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (i_rx_en && fall_c) begin
                    state_nxt   = ST_START;
                    bit_nxt     = '0;
                    data_nxt    = '0;
                    par_nxt     = 1'b0;
                    ferr_nxt    = 1'b0;
                    perr_nxt    = 1'b0;
                    nbits_nxt   = data_bits_decode(i_data_bits);
                    use_par_nxt = i_use_parity;
                    odd_nxt     = i_parity_odd;
                    stop2_nxt   = i_stop_bits;
                end
            end
            ST_START: begin
                if (sample_c && vote_c) begin
                    state_nxt = ST_IDLE;
                end else if (wrap_c) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (sample_c) begin
                    data_nxt[bit_q] = vote_c;
                end
                if (wrap_c) begin
                    if ({1'b0, bit_q} == nbits_q - 4'd1) begin
                        state_nxt = use_par_q ? ST_PARITY : ST_STOP0;
                    end else begin
                        bit_nxt = bit_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (sample_c) begin
                    par_nxt  = vote_c;
                    perr_nxt = ((^data_q) ^ vote_c) != odd_q;
                end
                if (wrap_c) begin
                    state_nxt = ST_STOP0;
                end
            end
            ST_STOP0: begin
                if (sample_c) begin
                    ferr_nxt = ~vote_c;
                    if ((data_q == '0) && (!use_par_q || !par_q) && !vote_c) begin
                        brk_nxt   = 1'b1;
                        state_nxt = ST_WAIT_IDLE;
                    end else if (!stop2_q) begin
                        wr_nxt    = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else if (wrap_c && stop2_q) begin
                    state_nxt = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (sample_c) begin
                    ferr_nxt  = ferr_q | ~vote_c;
                    wr_nxt    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (sample_c && vote_c) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        entry_nxt[RX_FERR_BIT]     = ferr_nxt;
        entry_nxt[RX_PERR_BIT]     = perr_nxt;
        entry_nxt[RX_DATA_W-1:0]   = data_nxt;
    end

    sync_fifo_fwft_with_clear #(
        .DATA_WIDTH (RX_ENTRY_W),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (~rst),
        .clear     (i_fifo_clear),
        .wr_en     (wr_q),
        .wr_data   (entry_q),
        .rd_en     (i_fifo_rd_en),
        .rd_data   (o_fifo_rd_data),
        .empty     (o_fifo_empty),
        .full      (o_fifo_full),
        .level     (o_fifo_level),
        .overflow  (o_overflow_error),
        .underflow (o_underflow_error)
    );

    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_q, thresh_q;
    logic            to_rst_c;

    // Any FIFO activity or line activity restarts the idle measurement
    assign to_rst_c = wr_q || (i_fifo_rd_en && !o_fifo_empty) || i_fifo_clear || (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
            thresh_q  <= 1'b0;
        end else begin
            if (to_rst_c) begin
                to_cnt_q <= '0;
            end else if (i_os_tick && (to_cnt_q != TO_W'(TO_TICKS))) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
            timeout_q <= !to_rst_c && (to_cnt_q == TO_W'(TO_TICKS)) && !o_fifo_empty;
            thresh_q  <= (o_fifo_level >= i_fifo_thresh) && (i_fifo_thresh != '0);
        end
    end

    assign o_timeout = timeout_q;
    assign o_thresh  = thresh_q;
    assign o_break   = brk_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed scoreboard bench for uart_rx_os (OVERSAMPLE=16, FIFO_DEPTH=16, tick every 4 clocks).
module tb_uart_rx_os;

    localparam int BIT_CLKS = 64;
    localparam int WR_OFS   = 616;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_os_tick;
    logic       i_rx_en;
    logic [1:0] i_data_bits;
    logic       i_use_parity;
    logic       i_parity_odd;
    logic       i_stop_bits;
    logic       i_uart_rx;
    logic       i_fifo_clear;
    logic       i_fifo_rd_en;
    logic [4:0] i_fifo_thresh;
    logic [9:0] o_fifo_rd_data;
    logic       o_fifo_empty;
    logic       o_fifo_full;
    logic [4:0] o_fifo_level;
    logic       o_thresh;
    logic       o_timeout;
    logic       o_break;
    logic       o_overflow_error;
    logic       o_underflow_error;

    int vectors = 0;
    int errors  = 0;
    int brk_cnt = 0;
    int ovf_cnt = 0;
    int unf_cnt = 0;
    logic [9:0] exp_q[$];

    uart_rx_os #(.FIFO_DEPTH(16), .OVERSAMPLE(16), .TIMEOUT_CHARS(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_os_tick         (i_os_tick),
        .i_rx_en           (i_rx_en),
        .i_data_bits       (i_data_bits),
        .i_use_parity      (i_use_parity),
        .i_parity_odd      (i_parity_odd),
        .i_stop_bits       (i_stop_bits),
        .i_uart_rx         (i_uart_rx),
        .i_fifo_clear      (i_fifo_clear),
        .i_fifo_rd_en      (i_fifo_rd_en),
        .i_fifo_thresh     (i_fifo_thresh),
        .o_fifo_rd_data    (o_fifo_rd_data),
        .o_fifo_empty      (o_fifo_empty),
        .o_fifo_full       (o_fifo_full),
        .o_fifo_level      (o_fifo_level),
        .o_thresh          (o_thresh),
        .o_timeout         (o_timeout),
        .o_break           (o_break),
        .o_overflow_error  (o_overflow_error),
        .o_underflow_error (o_underflow_error)
    );

    always #5 clk = ~clk;

    initial begin
        i_os_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            i_os_tick = 1'b1;
            @(negedge clk);
            i_os_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (o_break)           brk_cnt++;
        if (o_overflow_error)  ovf_cnt++;
        if (o_underflow_error) unf_cnt++;
    end

    initial begin
        #(10 * 80000);
        $display("FAIL watchdog: observed no end, expected end within 80000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        i_uart_rx = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_char(input logic [7:0] d, input int nbits, input logic par_en,
                             input logic odd, input logic stop2, input logic par_flip,
                             input logic stop2_low);
        logic p;
        p = odd;
        bit_time(1'b0);
        for (int i = 0; i < nbits; i++) begin
            bit_time(d[i]);
            p = p ^ d[i];
        end
        if (par_en) bit_time(p ^ par_flip);
        bit_time(1'b1);
        if (stop2) bit_time(!stop2_low);
        i_uart_rx = 1'b1;
    endtask

    task automatic send_8n1(input logic [7:0] d);
        send_char(d, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Land on the negedge just after a tick so frame timing is cycle-exact
    task automatic align_tick();
        @(posedge clk iff i_os_tick);
        @(negedge clk);
    endtask

    task automatic pop_check(input string tag);
        logic [9:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3ff;
        check(tag, 32'(o_fifo_rd_data), 32'(e));
        i_fifo_rd_en = 1'b1;
        @(negedge clk);
        i_fifo_rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i_rx_en = 1'b1;
        i_data_bits = 2'd3;
        i_use_parity = 1'b0;
        i_parity_odd = 1'b0;
        i_stop_bits = 1'b0;
        i_uart_rx = 1'b1;
        i_fifo_clear = 1'b0;
        i_fifo_rd_en = 1'b0;
        i_fifo_thresh = 5'd0;
        repeat (4) @(negedge clk);
        check("rst_empty", 32'(o_fifo_empty), 32'd1);
        check("rst_level", 32'(o_fifo_level), 32'd0);
        check("rst_rdata", 32'(o_fifo_rd_data), 32'd0);
        check("rst_full", 32'(o_fifo_full), 32'd0);
        check("rst_flags", 32'({o_thresh, o_timeout, o_break, o_overflow_error, o_underflow_error}), 32'd0);
        rst = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);

        // 8N1 0xA5, write lands exactly one cycle after the stop sample tick
        exp_q.push_back(10'h0a5);
        align_tick();
        fork
            send_8n1(8'ha5);
            begin
                repeat (WR_OFS) @(negedge clk);
                check("a5_before_wr", 32'(o_fifo_level), 32'd0);
                @(negedge clk);
                check("a5_after_wr", 32'(o_fifo_level), 32'd1);
            end
        join
        pop_check("a5_data");
        check("a5_empty", 32'(o_fifo_empty), 32'd1);

        // 7O2 0x35 with bad parity and low second stop
        i_data_bits = 2'd2; i_use_parity = 1'b1; i_parity_odd = 1'b1; i_stop_bits = 1'b1;
        exp_q.push_back(10'h335);
        send_char(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("7o2_level", 32'(o_fifo_level), 32'd1);
        pop_check("7o2_data");

        // 6-tick glitch is rejected as a false start
        i_data_bits = 2'd3; i_use_parity = 1'b0; i_parity_odd = 1'b0; i_stop_bits = 1'b0;
        i_uart_rx = 1'b0;
        repeat (24) @(negedge clk);
        i_uart_rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("glitch_level", 32'(o_fifo_level), 32'd0);
        check("glitch_break", 32'(brk_cnt), 32'd0);

        // Break: line low for two frames
        i_uart_rx = 1'b0;
        repeat (20 * BIT_CLKS) @(negedge clk);
        i_uart_rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("break_pulses", 32'(brk_cnt), 32'd1);
        check("break_level", 32'(o_fifo_level), 32'd0);
        exp_q.push_back(10'h055);
        send_8n1(8'h55);
        repeat (2) @(negedge clk);
        pop_check("after_break");

        // 17 characters into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(10'(8'(i * 13 + 7)));
            send_8n1(8'(i * 13 + 7));
        end
        repeat (2) @(negedge clk);
        check("ovf_level", 32'(o_fifo_level), 32'd16);
        check("ovf_full", 32'(o_fifo_full), 32'd1);
        check("ovf_pulses", 32'(ovf_cnt), 32'd1);

        // Pop in the write cycle at full: accepted, no overflow
        exp_q.push_back(10'h0c3);
        align_tick();
        fork
            send_8n1(8'hc3);
            begin
                logic [9:0] e;
                repeat (WR_OFS) @(negedge clk);
                e = exp_q.pop_front();
                check("full_head", 32'(o_fifo_rd_data), 32'(e));
                i_fifo_rd_en = 1'b1;
                @(negedge clk);
                i_fifo_rd_en = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        check("rdwr_level", 32'(o_fifo_level), 32'd16);
        check("rdwr_ovf", 32'(ovf_cnt), 32'd1);
        pop_check("fifo_order");

        // Clear coincident with a write wins
        align_tick();
        fork
            send_8n1(8'h99);
            begin
                repeat (WR_OFS) @(negedge clk);
                i_fifo_clear = 1'b1;
                @(negedge clk);
                i_fifo_clear = 1'b0;
            end
        join
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("clr_level", 32'(o_fifo_level), 32'd0);
        check("clr_empty", 32'(o_fifo_empty), 32'd1);
        check("clr_no_ovf", 32'(ovf_cnt), 32'd1);
        check("clr_no_unf", 32'(unf_cnt), 32'd0);

        // Underflow
        i_fifo_rd_en = 1'b1;
        @(negedge clk);
        i_fifo_rd_en = 1'b0;
        repeat (2) @(negedge clk);
        check("unf_pulses", 32'(unf_cnt), 32'd1);
        check("unf_level", 32'(o_fifo_level), 32'd0);

        // Threshold and receive timeout
        i_fifo_thresh = 5'd2;
        exp_q.push_back(10'h011);
        send_8n1(8'h11);
        repeat (2) @(negedge clk);
        check("thr_one", 32'(o_thresh), 32'd0);
        exp_q.push_back(10'h0e2);
        send_8n1(8'he2);
        repeat (2) @(negedge clk);
        check("thr_two", 32'(o_thresh), 32'd1);
        exp_q.push_back(10'h07f);
        send_8n1(8'h7f);
        repeat (2400) @(negedge clk);
        check("to_early", 32'(o_timeout), 32'd0);
        repeat (240) @(negedge clk);
        check("to_set", 32'(o_timeout), 32'd1);
        pop_check("to_pop1");
        @(negedge clk);
        check("to_drop", 32'(o_timeout), 32'd0);
        pop_check("to_pop2");
        pop_check("to_pop3");
        @(negedge clk);
        check("final_empty", 32'(o_fifo_empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
